// File: rtl/data_memory_ctrl.sv
// Purpose: byte/half/word data memory for the single-cycle datapath, with a post-reset clear sequencer and misalignment detection.
// Latency: loads are combinational (0 cycles); stores commit on the next rising edge of clk_i; the clear takes DEPTH edges after reset.
// Backpressure: none; accesses are ignored while ready_o=0. Optional macro DMEM_ERR_CNT_EN adds the err_count_o saturating error counter.
module data_memory_ctrl #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [31:0]           wdata_i,
    input  logic                  memwrite_i,
    input  logic                  memread_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    output logic [31:0]           rdata_o,
    output logic                  ready_o,
    output logic                  misaligned_o,
`ifdef DMEM_ERR_CNT_EN
    output logic [7:0]            err_count_o,
`endif
    output logic                  fault_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Decoded view of the incoming access, grouped so the datapath reads cleanly.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       lane;
        logic [1:0]       size;
        logic             uns;
        logic             rd;
        logic             wr;
    } req_t;

    state_t           state;
    logic [IDX_W-1:0] clr_cnt;
    logic [31:0]      mem [DEPTH];

    req_t             req;
    logic             illegal;
    logic             active;
    logic             do_store;
    logic             do_load;
    logic [3:0]       byte_en;
    logic [31:0]      wr_word;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_val;

    // Split the byte address into word index and little-endian byte lane.
    always_comb begin
        req.idx  = address_i[ADDR_WIDTH-1:2];
        req.lane = address_i[1:0];
        req.size = size_i;
        req.uns  = unsigned_i;
        req.rd   = memread_i;
        req.wr   = memwrite_i;
    end

    // Alignment rules: halfwords need an even address, words a multiple of four, size 11 is never legal.
    always_comb begin
        illegal = 1'b0;
        case (req.size)
            SZ_BYTE: illegal = 1'b0;
            SZ_HALF: illegal = req.lane[0];
            SZ_WORD: illegal = (req.lane != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // An access only counts once the clear has finished; during clear the strobes are ignored outright.
    always_comb begin
        active       = (state == ST_READY) && (req.rd || req.wr);
        misaligned_o = active && illegal;
        do_store     = (state == ST_READY) && req.wr && !illegal;
        do_load      = (state == ST_READY) && req.rd && !illegal;
    end

    // Byte-enable mask and lane-replicated write data so each lane just picks its own slice.
    always_comb begin
        byte_en = 4'b0000;
        wr_word = wdata_i;
        case (req.size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << req.lane;
                wr_word = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                byte_en = req.lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                byte_en = 4'b1111;
                wr_word = wdata_i;
            end
            default: begin
                byte_en = 4'b0000;
                wr_word = wdata_i;
            end
        endcase
    end

    // Storage: the clear sequencer owns the write port until READY, then aligned stores write their enabled lanes.
    always_ff @(posedge clk_i) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= 32'h0;
        end else if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[req.idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // Lane selection for loads; the array read is asynchronous so a same-word store shows old data until the edge.
    always_comb begin
        rd_word = mem[req.idx];
        rd_byte = 8'h00;
        case (req.lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = req.lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Right-align and extend; anything that is not a legal load in READY reads as zero.
    always_comb begin
        load_val = 32'h0;
        case (req.size)
            SZ_BYTE: load_val = req.uns ? {24'h0, rd_byte}
                                        : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: load_val = req.uns ? {16'h0, rd_half}
                                        : {{16{rd_half[15]}}, rd_half};
            SZ_WORD: load_val = rd_word;
            default: load_val = 32'h0;
        endcase
        rdata_o = do_load ? load_val : 32'h0;
    end

    // Clear/ready sequencer plus the sticky fault flag; reset always restarts the clear at word 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ready_o <= 1'b0;
            fault_o <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_IDX) begin
                        state   <= ST_READY;
                        ready_o <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    if (misaligned_o) begin
                        fault_o <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef DMEM_ERR_CNT_EN
    // Saturating count of edges that saw a misaligned or illegal access in READY.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_count_o <= 8'h00;
        end else if (misaligned_o && (err_count_o != 8'hFF)) begin
            err_count_o <= err_count_o + 8'h01;
        end
    end
`endif

endmodule
